// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the scan decoder family.
//   IDLE/DIRECT/SCAN : registered state encoding
//   onehot()         : index -> one-hot line vector (indices up to MAX_N bits)
//   clog2()          : ceiling log2 for sizing counters
package decoder_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  // Widest select supported by onehot(); callers cast down to their own width.
  localparam int unsigned MAX_N    = 8;
  localparam int unsigned MAX_OUTS = 1 << MAX_N;

  function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] idx);
    return MAX_OUTS'(1) << idx;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts 0..DIV-1 while enabled, wraps to 0 after DIV-1.
//   clk, rst  : clock, async active-high reset
//   i_clr     : synchronous clear (priority over i_en)
//   i_en      : advance the count
//   o_tick_c  : combinational, high while the count sits at DIV-1
module dwell_counter
  import decoder_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick_c
);

  localparam int unsigned DW = (DIV <= 1) ? 1 : clog2(DIV);

  logic [DW-1:0] r_cnt;
  logic          w_tick;

  // With DIV=1 the count never leaves 0, so the tick is permanently high.
  assign w_tick   = (r_cnt == DW'(DIV - 1));
  assign o_tick_c = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and auto-scan mode.
//   clk, rst : clock, async active-high reset
//   ena      : 0 = all lines deasserted and scan frozen
//   mode     : 0 = direct decode of n, 1 = auto-scan
//   load     : scan mode only, jump to line n and restart the dwell
//   n        : direct select / scan load value
//   d        : decoded lines (asserted low when ACTIVE_LOW)
//   sel      : index of the selected line
//   valid    : d carries exactly one asserted line
//   wrap     : one-cycle pulse when the scan steps from the last line to 0
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  mode,
  input  logic                  load,
  input  logic [N-1:0]          n,
  output logic [(1 << N)-1:0]   d,
  output logic [N-1:0]          sel,
  output logic                  valid,
  output logic                  wrap
);

  // N is limited to MAX_N by the package onehot() helper.
  localparam int unsigned     OUTS     = 1 << N;
  localparam logic [OUTS-1:0] DEASSERT = {OUTS{ACTIVE_LOW}};

  logic [1:0]      r_state;
  logic [N-1:0]    r_sel;
  logic [OUTS-1:0] r_d;
  logic            r_wrap;

  logic [1:0]      w_state_nxt;
  logic [N-1:0]    w_sel_nxt;
  logic [OUTS-1:0] w_d_nxt;
  logic            w_wrap_nxt;
  logic            w_clr;
  logic            w_en;
  logic            w_tick;

  dwell_counter #(
    .DIV (DIV)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_tick_c (w_tick)
  );

  // Next state, next select and dwell control; n/mode/load are not read in IDLE.
  always_comb begin
    w_state_nxt = IDLE;
    w_sel_nxt   = r_sel;
    w_wrap_nxt  = 1'b0;
    w_clr       = 1'b0;
    w_en        = 1'b0;

    if (ena) w_state_nxt = mode ? SCAN : DIRECT;

    case (w_state_nxt)
      DIRECT: begin
        w_sel_nxt = n;
        w_clr     = 1'b1;
      end
      SCAN: begin
        if (load) begin
          w_sel_nxt = n;
          w_clr     = 1'b1;
        end else begin
          w_en = 1'b1;
          if (w_tick) begin
            w_sel_nxt  = r_sel + N'(1);
            w_wrap_nxt = (r_sel == N'(OUTS - 1));
          end
        end
      end
      default: ;
    endcase

    // XOR with the idle pattern applies the output polarity.
    w_d_nxt = DEASSERT;
    if (w_state_nxt != IDLE) w_d_nxt = OUTS'(onehot(MAX_N'(w_sel_nxt))) ^ DEASSERT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_d     <= DEASSERT;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_d     <= w_d_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign d     = r_d;
  assign sel   = r_sel;
  assign wrap  = r_wrap;
  // Every non-IDLE state drives exactly one line.
  assign valid = (r_state != IDLE);

endmodule
